ring_johnson_counter: RTL

- Parametrised shift-register counter, successor to the fixed 4-bit ring counter.
- Runtime-selectable ring (one-hot) or Johnson (twisted-ring) mode, selectable direction, count enable and parallel load.
- Detects illegal states and self-corrects them; reports a registered phase index and a wrap pulse.
- Used as a phase/sequence generator driving one-hot select lines elsewhere in the design.

---
 rtl/ring_johnson_counter.sv | 108 ++++++++++
 1 files changed

// File: rtl/ring_johnson_counter.sv
// Parametrised ring / Johnson shift-register counter with direction, load,
// illegal-state self-correction, registered phase index and wrap/error pulses.
module ring_johnson_counter #(
    parameter  int WIDTH = 4,
    localparam int PW    = $clog2(2*WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             Mode,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_value,
    output logic [WIDTH-1:0] Count_out,
    output logic [PW-1:0]    Phase,
    output logic             Wrap,
    output logic             Error
);

    localparam logic [WIDTH-1:0] RING_SEED = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] JOHN_SEED = '0;

    logic             mode_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             error_d;

    function automatic int popcount(input logic [WIDTH-1:0] c);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(c[i]);
        return n;
    endfunction

    // Johnson legality counts transitions along the word, not around it.
    function automatic logic is_legal(input logic mode, input logic [WIDTH-1:0] c);
        int t = 0;
        if (!mode) return (popcount(c) == 1);
        for (int i = 0; i < WIDTH-1; i++) if (c[i] != c[i+1]) t++;
        return (t <= 1);
    endfunction

    function automatic logic [WIDTH-1:0] seed_of(input logic mode);
        return mode ? JOHN_SEED : RING_SEED;
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic mode, input logic dir,
                                              input logic [WIDTH-1:0] c);
        logic fb;
        fb = dir ? c[0] : c[WIDTH-1];
        if (mode) fb = ~fb;
        return dir ? {fb, c[WIDTH-1:1]} : {c[WIDTH-2:0], fb};
    endfunction

    function automatic logic [PW-1:0] phase_of(input logic mode, input logic [WIDTH-1:0] c);
        int p  = 0;
        int pc = popcount(c);
        if (!mode) begin
            for (int i = 0; i < WIDTH; i++) if (c[i]) p = i;
        end else if (c[0]) begin
            p = pc;
        end else if (pc != 0) begin
            p = 2*WIDTH - pc;
        end
        return p[PW-1:0];
    endfunction

    always_comb begin
        count_d = Count_out;
        wrap_d  = 1'b0;
        error_d = 1'b0;
        if (Mode != mode_q) begin
            count_d = seed_of(Mode);
        end else if (Load) begin
            if (is_legal(Mode, Load_value)) begin
                count_d = Load_value;
            end else begin
                count_d = seed_of(Mode);
                error_d = 1'b1;
            end
        end else if (Enable) begin
            if (!is_legal(Mode, Count_out)) begin
                count_d = seed_of(Mode);
                error_d = 1'b1;
            end else begin
                count_d = step(Mode, Dir, Count_out);
                wrap_d  = (count_d == seed_of(Mode));
            end
        end
    end

    // Phase tracks count_d so it always describes the Count_out beside it.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Count_out <= RING_SEED;
            Phase     <= '0;
            Wrap      <= 1'b0;
            Error     <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            Count_out <= count_d;
            Phase     <= phase_of(Mode, count_d);
            Wrap      <= wrap_d;
            Error     <= error_d;
            mode_q    <= Mode;
        end
    end

endmodule
